// File: rtl/mips_display_wr_ctrl.sv
// mips_display_wr_ctrl: shares the VGA block display's single write port
// between buffered CPU stores and a clear-screen fill engine, with
// round-robin arbitration when both have work.
// Optional: define DISPLAY_WR_CTRL_STATS_EN to count dropped out-of-range
// CPU writes on dropped_count (saturating at 255). When it is not defined,
// dropped_count is tied to 0.
module mips_display_wr_ctrl #(
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_wr_valid,
  input  logic [13:0] cpu_wr_data,
  output logic        cpu_wr_ready,
  input  logic        fill_start,
  input  logic [2:0]  fill_color,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        disp_we,
  output logic [13:0] disp_data,
  output logic [7:0]  dropped_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [5:0]    X_LAST   = 6'(GRID_W - 1);
  localparam logic [4:0]    Y_LAST   = 5'(GRID_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      color_q, color_d;
  logic [5:0]      fx_q, fx_d;
  logic [4:0]      fy_q, fy_d;
  logic [13:0]     fifo_mem_q [FIFO_DEPTH];
  logic [13:0]     fifo_mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rr_fill_q, rr_fill_d;   // 1: fill won the last grant
  logic            disp_we_q, disp_we_d;
  logic [13:0]     disp_data_q, disp_data_d;

  logic cpu_acc, in_range, push, pop, cpu_req, fill_req, gnt_fill, gnt_cpu;

  // Handshake, range check and arbitration decision
  always_comb begin
    cpu_wr_ready = (cnt_q != FULL_CNT);
    in_range = ({1'b0, cpu_wr_data[10:5]} < 7'(GRID_W)) &&
               ({1'b0, cpu_wr_data[4:0]}  < 6'(GRID_H));
    cpu_acc  = cpu_wr_valid && cpu_wr_ready;
    push     = cpu_acc && in_range;
    cpu_req  = (cnt_q != '0);
    fill_req = (state_q == S_FILL);
    // With both pending, the requester that did not win last time gets it.
    gnt_fill = fill_req && (!cpu_req || !rr_fill_q);
    gnt_cpu  = cpu_req && !gnt_fill;
    pop      = gnt_cpu;
  end

  // FIFO next state; a pop and push in the same cycle both take effect
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = cpu_wr_data;
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // Fill FSM: walk the grid row-major, one cell per fill grant
  always_comb begin
    state_d = state_q;
    color_d = color_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    unique case (state_q)
      S_IDLE: if (fill_start) begin
        color_d = fill_color;
        fx_d    = '0;
        fy_d    = '0;
        state_d = S_FILL;
      end
      S_FILL: if (gnt_fill) begin
        if (fx_q == X_LAST) begin
          fx_d = '0;
          if (fy_q == Y_LAST) state_d = S_DONE;
          else                fy_d = fy_q + 5'd1;
        end else begin
          fx_d = fx_q + 6'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output word selection; data holds when nothing is granted
  always_comb begin
    disp_we_d   = gnt_fill || gnt_cpu;
    disp_data_d = disp_data_q;
    rr_fill_d   = rr_fill_q;
    if (gnt_fill) begin
      disp_data_d = {color_q, fx_q, fy_q};
      rr_fill_d   = 1'b1;
    end else if (gnt_cpu) begin
      disp_data_d = fifo_mem_q[rd_ptr_q];
      rr_fill_d   = 1'b0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      color_q     <= '0;
      fx_q        <= '0;
      fy_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rr_fill_q   <= 1'b0;
      disp_we_q   <= 1'b0;
      disp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      color_q     <= color_d;
      fx_q        <= fx_d;
      fy_q        <= fy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rr_fill_q   <= rr_fill_d;
      disp_we_q   <= disp_we_d;
      disp_data_q <= disp_data_d;
    end
  end

  // FIFO storage; contents are meaningless while the count is zero
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign fill_busy = (state_q == S_FILL);
  assign fill_done = (state_q == S_DONE);
  assign disp_we   = disp_we_q;
  assign disp_data = disp_data_q;

`ifdef DISPLAY_WR_CTRL_STATS_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of accepted-but-discarded CPU words
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (cpu_acc && !in_range && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Drop counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign dropped_count = drop_cnt_q;
`else
  assign dropped_count = 8'd0;
`endif

endmodule

// File: tb/tb_mips_display_wr_ctrl.sv
// Directed bench for mips_display_wr_ctrl.
module tb_mips_display_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_wr_valid = 1'b0;
  logic [13:0] cpu_wr_data = '0;
  logic        cpu_wr_ready;
  logic        fill_start = 1'b0;
  logic [2:0]  fill_color = '0;
  logic        fill_busy, fill_done, disp_we;
  logic [13:0] disp_data;
  logic [7:0]  dropped_count;

  mips_display_wr_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_data(cpu_wr_data), .cpu_wr_ready(cpu_wr_ready),
    .fill_start(fill_start), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .disp_we(disp_we), .disp_data(disp_data), .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_err = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          cpu_seen = 0;
  logic [13:0] wq[$];
  int          wc[$];

  always @(posedge clk) cyc++;

  // Record every display write, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && disp_we) begin
      wq.push_back(disp_data);
      wc.push_back(cyc);
      if (disp_data[13:11] == 3'b111) cpu_seen++;
    end
    if (fill_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cpu_wr_valid = 1'b0; fill_start = 1'b0;
    repeat (2) tick();
    @(negedge clk); rst_n = 1'b1;
    tick();
    wq.delete(); wc.delete(); done_cnt = 0; cpu_seen = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!fill_done && n < 5000) begin tick(); n++; end
    chk({tag, "_done_seen"}, 32'(n < 5000), 1);
    tick();
  endtask

  function automatic logic [13:0] fw(input logic [2:0] c, input int x, input int y);
    return {c, 6'(x), 5'(y)};
  endfunction

  function automatic logic [13:0] cw(input int i);
    return {3'b111, 6'(i), 5'd3};
  endfunction

  initial begin
    int          bad, sent, occ, guard, ci;
    logic        r, saw_full;
    logic [13:0] oor [3];
    logic [13:0] cpu_words[$];
    int          exp_drop;

    // Reset state
    #3;
    chk("rst_ready", cpu_wr_ready, 1);
    chk("rst_we", disp_we, 0);
    chk("rst_data", disp_data, 0);
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_drop", dropped_count, 0);
    do_reset();

    // 1: single CPU write, two edges to the display
    cpu_wr_valid = 1'b1; cpu_wr_data = 14'b101_000101_00111;
    tick();
    cpu_wr_valid = 1'b0;
    chk("t1_we_early", disp_we, 0);
    tick();
    chk("t1_we", disp_we, 1);
    chk("t1_data", disp_data, 14'b101_000101_00111);
    tick();
    chk("t1_we_after", disp_we, 0);
    repeat (3) tick();
    chk("t1_count", wq.size(), 1);

    // 2: fill alone
    do_reset();
    fill_color = 3'b010; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("t2_busy", fill_busy, 1);
    wait_done("t2");
    chk("t2_busy_low", fill_busy, 0);
    chk("t2_done_low", fill_done, 0);
    chk("t2_done_pulses", done_cnt, 1);
    chk("t2_count", wq.size(), 1200);
    if (wq.size() == 1200) begin
      chk("t2_first", wq[0], fw(3'b010, 0, 0));
      chk("t2_40th", wq[39], fw(3'b010, 39, 0));
      chk("t2_41st", wq[40], fw(3'b010, 0, 1));
      chk("t2_last", wq[1199], fw(3'b010, 39, 29));
      chk("t2_consecutive", wc[1199] - wc[0], 1199);
      bad = 0;
      for (int i = 0; i < 1200; i++)
        if (wq[i] !== fw(3'b010, i % 40, i / 40)) bad++;
      chk("t2_order", bad, 0);
    end

    // 3: fill with a continuously busy CPU
    do_reset();
    fill_color = 3'b010; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    sent = 0; guard = 0; saw_full = 1'b0;
    cpu_wr_valid = 1'b1; cpu_wr_data = cw(0);
    while (sent < 20 && guard < 200) begin
      @(negedge clk); #2;
      occ = sent - cpu_seen;
      r = cpu_wr_ready;
      chk("t3_ready", r, 32'(occ != 4));
      if (!r) saw_full = 1'b1;
      @(posedge clk); #1;
      if (r) begin sent++; cpu_wr_data = cw(sent); end
      guard++;
    end
    cpu_wr_valid = 1'b0;
    chk("t3_sent", sent, 20);
    wait_done("t3");
    chk("t3_saw_full", saw_full, 1);
    bad = 0;
    for (int i = 0; i < 36; i++)
      if (wq[i][13:11] == wq[i+1][13:11]) bad++;
    chk("t3_alternate", bad, 0);
    cpu_words.delete();
    foreach (wq[i]) if (wq[i][13:11] == 3'b111) cpu_words.push_back(wq[i]);
    chk("t3_cpu_count", cpu_words.size(), 20);
    bad = 0;
    foreach (cpu_words[i]) if (cpu_words[i] !== cw(i)) bad++;
    chk("t3_cpu_order", bad, 0);
    chk("t3_total", wq.size(), 1220);

    // 4: out-of-range writes are accepted and dropped
    do_reset();
    oor[0] = {3'b001, 6'd40, 5'd0};
    oor[1] = {3'b001, 6'd0, 5'd30};
    oor[2] = {3'b001, 6'd63, 5'd31};
    for (int i = 0; i < 3; i++) begin
      cpu_wr_valid = 1'b1; cpu_wr_data = oor[i];
      chk("t4_ready", cpu_wr_ready, 1);
      tick();
    end
    cpu_wr_valid = 1'b0;
    repeat (3) tick();
    chk("t4_no_we", wq.size(), 0);
`ifdef DISPLAY_WR_CTRL_STATS_EN
    exp_drop = 3;
`else
    exp_drop = 0;
`endif
    chk("t4_drop3", dropped_count, exp_drop);
    cpu_wr_valid = 1'b1; cpu_wr_data = oor[0];
    repeat (300) tick();
    cpu_wr_valid = 1'b0;
    tick();
`ifdef DISPLAY_WR_CTRL_STATS_EN
    exp_drop = 255;
`else
    exp_drop = 0;
`endif
    chk("t4_drop_sat", dropped_count, exp_drop);
    chk("t4_no_we_bulk", wq.size(), 0);

    // 5: restart during a fill is ignored
    do_reset();
    fill_color = 3'b001; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    repeat (10) tick();
    fill_color = 3'b110; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    wait_done("t5");
    chk("t5_count", wq.size(), 1200);
    bad = 0;
    foreach (wq[i]) if (wq[i][13:11] != 3'b001) bad++;
    chk("t5_colour", bad, 0);
    if (wq.size() == 1200) chk("t5_last", wq[1199], fw(3'b001, 39, 29));
    chk("t5_done_pulses", done_cnt, 1);

    // 6: reset in the middle of a fill with CPU words pending
    do_reset();
    fill_color = 3'b011; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    guard = 0;
    while (wq.size() < 100 && guard < 500) begin tick(); guard++; end
    chk("t6_reach100", 32'(guard < 500), 1);
    for (ci = 0; ci < 3; ci++) begin
      cpu_wr_valid = 1'b1; cpu_wr_data = cw(ci);
      tick();
    end
    cpu_wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_we", disp_we, 0);
    chk("t6_busy", fill_busy, 0);
    chk("t6_ready", cpu_wr_ready, 1);
    repeat (2) tick();
    @(negedge clk); rst_n = 1'b1;
    wq.delete();
    repeat (30) tick();
    chk("t6_no_stale", wq.size(), 0);
    chk("t6_busy_after", fill_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
